// File: rtl/prbs_block_generator.sv
// prbs_block_generator: N_LANES-byte test-block source (PRBS11 / counter / fixed / zero) with
// a valid/ready output. Lane-0 error injection exists only when PRBS_ERR_INJECT_EN is defined.
module prbs_block_generator #(
   parameter int          N_LANES        = 8,
   parameter logic [10:0] SEED           = 11'h7FF,
   parameter logic [10:0] LANE_SEED_STEP = 11'h0A5,
   parameter int          CNT_W          = 32
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_restart,
   input  logic [1:0]           i_mode,
   input  logic [7:0]           i_pattern,
   input  logic                 i_ready,
`ifdef PRBS_ERR_INJECT_EN
   input  logic                 i_inject,
`endif
   output logic [8*N_LANES-1:0] o_data_block,
   output logic                 o_valid,
   output logic [CNT_W-1:0]     o_block_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // A zero seed would lock the LFSR, so it is replaced by all-ones.
   function automatic logic [10:0] lane_seed(input int k);
      logic [10:0] s;
      s = SEED ^ 11'(k * int'(LANE_SEED_STEP));
      return (s == 11'd0) ? 11'h7FF : s;
   endfunction

   function automatic logic [18:0] prbs_step8(input logic [10:0] s_in);
      logic [10:0] s;
      logic [7:0]  b;
      logic        nb;
      s = s_in;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         nb       = s[10] ^ s[8];
         b[7 - i] = nb;
         s        = {s[9:0], nb};
      end
      return {s, b};
   endfunction

   logic [10:0]          lfsr_q   [N_LANES];
   logic [10:0]          lfsr_d   [N_LANES];
   logic [10:0]          lfsr_adv [N_LANES];
   logic [7:0]           prbs_b   [N_LANES];
   logic [7:0]           lane_b   [N_LANES];
   logic [8*N_LANES-1:0] blk;
   logic [8*N_LANES-1:0] data_q, data_d;
   logic [7:0]           gen_cnt_q, gen_cnt_d;
   logic                 valid_q, valid_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 gen, accept;
`ifdef PRBS_ERR_INJECT_EN
   logic                 inj_q, inj_d;
`endif

   assign gen    = i_enable && (!valid_q || i_ready);
   assign accept = valid_q && i_ready;

   always_comb begin
      blk = '0;
      for (int k = 0; k < N_LANES; k++) begin
         {lfsr_adv[k], prbs_b[k]} = prbs_step8(lfsr_q[k]);
         case (i_mode)
            2'd0:    lane_b[k] = prbs_b[k];
            2'd1:    lane_b[k] = gen_cnt_q + 8'(k);
            2'd2:    lane_b[k] = i_pattern;
            default: lane_b[k] = 8'h00;
         endcase
         blk[8*(N_LANES-1-k) +: 8] = lane_b[k];
      end
`ifdef PRBS_ERR_INJECT_EN
      // Flip only the emitted bit; the LFSR advance above is untouched.
      if (inj_q) blk[8*(N_LANES-1)] = ~blk[8*(N_LANES-1)];
`endif
   end

   always_comb begin
      lfsr_d    = lfsr_q;
      data_d    = data_q;
      gen_cnt_d = gen_cnt_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
`ifdef PRBS_ERR_INJECT_EN
      inj_d     = inj_q;
`endif
      if (i_restart) begin
         for (int k = 0; k < N_LANES; k++) lfsr_d[k] = lane_seed(k);
         gen_cnt_d = '0;
         valid_d   = 1'b0;
         cnt_d     = '0;
`ifdef PRBS_ERR_INJECT_EN
         inj_d     = 1'b0;
`endif
      end else begin
         if (gen) begin
            data_d    = blk;
            valid_d   = 1'b1;
            gen_cnt_d = gen_cnt_q + 8'd1;
            if (i_mode == 2'd0) lfsr_d = lfsr_adv;
         end else if (accept) begin
            valid_d = 1'b0;
         end
         if (accept) cnt_d = cnt_q + CNT_ONE;
`ifdef PRBS_ERR_INJECT_EN
         inj_d = (inj_q && !gen) || i_inject;
`endif
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int k = 0; k < N_LANES; k++) lfsr_q[k] <= lane_seed(k);
         data_q    <= '0;
         gen_cnt_q <= '0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
`ifdef PRBS_ERR_INJECT_EN
         inj_q     <= 1'b0;
`endif
      end else begin
         lfsr_q    <= lfsr_d;
         data_q    <= data_d;
         gen_cnt_q <= gen_cnt_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
`ifdef PRBS_ERR_INJECT_EN
         inj_q     <= inj_d;
`endif
      end
   end

   assign o_data_block  = data_q;
   assign o_valid       = valid_q;
   assign o_block_count = cnt_q;

endmodule

// File: tb/tb_prbs_block_generator.sv
// Scoreboard bench for prbs_block_generator: a cycle model pushes each generated block
// into a queue and the DUT output is compared against the queue head.
module tb_prbs_block_generator;
   localparam int N  = 8;
   localparam int W  = 8 * N;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable, restart, ready, inject;
   logic [1:0]    mode;
   logic [7:0]    pattern;
   logic [W-1:0]  o_data_block;
   logic          o_valid;
   logic [CW-1:0] o_block_count;

   always #5 clk = ~clk;

   prbs_block_generator #(
      .N_LANES(N), .SEED(11'h7FF), .LANE_SEED_STEP(11'h0A5), .CNT_W(CW)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst_n),
      .i_enable     (enable),
      .i_restart    (restart),
      .i_mode       (mode),
      .i_pattern    (pattern),
      .i_ready      (ready),
`ifdef PRBS_ERR_INJECT_EN
      .i_inject     (inject),
`endif
      .o_data_block (o_data_block),
      .o_valid      (o_valid),
      .o_block_count(o_block_count)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   logic [10:0]   m_lfsr [N];
   logic [7:0]    m_gcnt;
   logic          m_valid;
   logic [CW-1:0] m_count;
   logic          m_inj;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  last_gen;

   function automatic logic [10:0] ref_seed(input int k);
      logic [10:0] s;
      s = 11'h7FF ^ 11'(k * 'h0A5);
      if (s == 11'd0) s = 11'h7FF;
      return s;
   endfunction

   task automatic model_reseed();
      for (int k = 0; k < N; k++) m_lfsr[k] = ref_seed(k);
      m_gcnt  = '0;
      m_count = '0;
      m_valid = 1'b0;
      m_inj   = 1'b0;
      exp_q.delete();
   endtask

   // Check current outputs, advance the model by one edge, then step the clock.
   task automatic cycle();
      logic [W-1:0] b;
      logic [10:0]  s;
      logic [7:0]   lb;
      logic         fb, g, a;
      check("valid", 64'(o_valid), 64'(m_valid));
      check("count", 64'(o_block_count), 64'(m_count));
      if (m_valid && exp_q.size() > 0) check("data", 64'(o_data_block), 64'(exp_q[0]));
      if (restart) begin
         model_reseed();
      end else begin
         g = enable && (!m_valid || ready);
         a = m_valid && ready;
         if (a) begin
            m_count++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (g) begin
            b = '0;
            for (int k = 0; k < N; k++) begin
               case (mode)
                  2'd0: begin
                     s  = m_lfsr[k];
                     lb = '0;
                     for (int i = 0; i < 8; i++) begin
                        fb = s[10] ^ s[8];
                        lb = {lb[6:0], fb};
                        s  = {s[9:0], fb};
                     end
                     m_lfsr[k] = s;
                  end
                  2'd1:    lb = 8'(m_gcnt + 8'(k));
                  2'd2:    lb = pattern;
                  default: lb = 8'h00;
               endcase
               b[W-8-8*k +: 8] = lb;
            end
            if (m_inj) b[W-8] = ~b[W-8];
            exp_q.push_back(b);
            last_gen = b;
            m_gcnt++;
            m_valid = 1'b1;
         end else if (a) begin
            m_valid = 1'b0;
         end
         m_inj = (m_inj && !g) || inject;
      end
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0]  first_blk, held;
   logic [CW-1:0] c0;

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b1;
      restart = 1'b0;
      ready   = 1'b1;
      inject  = 1'b0;
      mode    = 2'd0;
      pattern = 8'h00;
      last_gen = '0;
      model_reseed();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_data", 64'(o_data_block), 64'd0);
      check("rst_count", 64'(o_block_count), 64'd0);
      rst_n = 1'b1;

      cycle();
      first_blk = last_gen;
      check("first_lane0", 64'(o_data_block[W-1 -: 8]), 64'h00);
      repeat (4096) cycle();
      check("count_4096", 64'(o_block_count), 64'd4096);

      // Backpressure: block held bit-stable, count frozen.
      held  = exp_q[0];
      c0    = m_count;
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("stall_hold", 64'(o_data_block), 64'(held));
         check("stall_valid", 64'(o_valid), 64'd1);
      end
      check("stall_count", 64'(o_block_count), 64'(c0));
      ready = 1'b1;
      repeat (3) cycle();
      check("bp_count", 64'(o_block_count), 64'(c0 + 3));

      // Enable dropped while stalled.
      ready = 1'b0;
      cycle();
      enable = 1'b0;
      repeat (3) cycle();
      check("en_drop_hold", 64'(o_valid), 64'd1);
      ready = 1'b1;
      cycle();
      check("en_drop_fall", 64'(o_valid), 64'd0);
      cycle();
      enable = 1'b1;
      repeat (5) cycle();

      // Counter mode after restart.
      mode    = 2'd1;
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      check("rs_valid", 64'(o_valid), 64'd0);
      check("rs_count", 64'(o_block_count), 64'd0);
      cycle();
      check("cnt_blk0", 64'(o_data_block), 64'h0001020304050607);
      cycle();
      check("cnt_blk1", 64'(o_data_block), 64'h0102030405060708);
      repeat (255) cycle();
      check("cnt_blk256", 64'(o_data_block), 64'h0001020304050607);

      // Fixed and zero modes.
      mode    = 2'd2;
      pattern = 8'hA5;
      cycle();
      check("fixed_a5", 64'(o_data_block), 64'hA5A5A5A5A5A5A5A5);
      cycle();
      mode = 2'd3;
      cycle();
      check("zero", 64'(o_data_block), 64'd0);

      // PRBS restart mid-stream repeats the first block after reset.
      mode = 2'd0;
      repeat (10) cycle();
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      check("rs2_valid", 64'(o_valid), 64'd0);
      check("rs2_count", 64'(o_block_count), 64'd0);
      cycle();
      check("restart_first", 64'(o_data_block), 64'(first_blk));
      repeat (20) cycle();

`ifdef PRBS_ERR_INJECT_EN
      inject = 1'b1;
      cycle();
      inject = 1'b0;
      cycle();
      check("inj_bit", 64'(o_data_block[W-8]), 64'(last_gen[W-8]));
      repeat (20) cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
